// File: rtl/timer_pkg.sv
// Shared types and default constants for the game countdown timer controller.
// Imported by game_timer_ctrl and tick_prescaler.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } timer_state_t;

   localparam int         TICK_DIV_DEF   = 100;
   localparam logic [3:0] START_TENS_DEF = 4'd6;
   localparam logic [3:0] START_ONES_DEF = 4'd0;

   // Prescaler width; a divider of 1 would give a zero-width counter, so floor at one bit.
   function automatic int presc_width(input int div);
      return (div > 2) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter that holds while disabled and flags the
// last count as a tick.
module tick_prescaler
   import timer_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int                CNT_W   = presc_width(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt;
   logic             at_max;

   assign at_max = (cnt == CNT_MAX);
   assign tick   = en && at_max;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; RST is tested inside the clocked block, making it synchronous.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= at_max ? '0 : cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/game_timer_ctrl.sv
// Countdown game timer control FSM driving an external two-digit BCD down-counter.
// Define GAME_TIMER_WARN_EN to build the registered low-time Warn output.
module game_timer_ctrl
   import timer_pkg::*;
#(
   parameter int         TICK_DIV   = TICK_DIV_DEF,
   parameter logic [3:0] START_TENS = START_TENS_DEF,
   parameter logic [3:0] START_ONES = START_ONES_DEF
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Start,
   input  logic       Stop,
   input  logic       Clear,
   input  logic [3:0] TensIn,
   input  logic [3:0] OnesIn,
   output logic       SetDigits,
   output logic [3:0] SetTens,
   output logic [3:0] SetOnes,
   output logic       CountPulse,
   output logic       Running,
   output logic       Done,
   output logic       Expired,
   output logic       Warn
);

   timer_state_t state;
   timer_state_t next_state;
   logic         tick;
   logic         presc_en;
   logic         presc_clr;
   logic         digits_zero;
   logic         digits_one;

   assign SetTens     = START_TENS;
   assign SetOnes     = START_ONES;
   assign digits_zero = (TensIn == 4'd0) && (OnesIn == 4'd0);
   assign digits_one  = (TensIn == 4'd0) && (OnesIn == 4'd1);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .CLK  (CLK),
      .RST  (RST),
      .en   (presc_en),
      .clr  (presc_clr),
      .tick (tick)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      if (Clear) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (Start) next_state = digits_zero ? ST_DONE : ST_RUN;
            // Reaching 00 outranks a same-cycle Stop: the last pulse empties the counter.
            ST_RUN: begin
               if (tick && digits_one) next_state = ST_DONE;
               else if (Stop)          next_state = ST_PAUSE;
            end
            ST_PAUSE: if (Start) next_state = ST_RUN;
            ST_DONE:  next_state = ST_DONE;
            default:  next_state = ST_IDLE;
         endcase
      end
   end

   // Prescaler is zeroed outside RUN/PAUSE so each fresh start gets a full tick period.
   always_comb begin
      SetDigits  = 1'b0;
      CountPulse = 1'b0;
      presc_en   = 1'b0;
      presc_clr  = 1'b0;
      case (state)
         ST_IDLE: begin
            SetDigits = 1'b1;
            presc_clr = 1'b1;
         end
         ST_RUN: begin
            presc_en   = 1'b1;
            CountPulse = tick;
         end
         ST_PAUSE: ;
         ST_DONE:  presc_clr = 1'b1;
         default:  presc_clr = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         Running <= 1'b0;
         Done    <= 1'b0;
         Expired <= 1'b0;
      end else begin
         Running <= (next_state == ST_RUN);
         Done    <= (next_state == ST_DONE);
         Expired <= (next_state == ST_DONE) && (state != ST_DONE);
      end
   end

`ifdef GAME_TIMER_WARN_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         Warn <= 1'b0;
      end else begin
         Warn <= ((next_state == ST_RUN) || (next_state == ST_PAUSE)) && (TensIn == 4'd0);
      end
   end
`else
   assign Warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl: three instances (presets 0:3, 1:0, 0:0, TICK_DIV=4)
// each wired to a two-digit BCD down-counter model, sharing one stimulus stream.
module tb_game_timer_ctrl;

`ifdef GAME_TIMER_WARN_EN
   localparam bit WARN_EN = 1'b1;
`else
   localparam bit WARN_EN = 1'b0;
`endif

   logic CLK;
   logic RST;
   logic Start;
   logic Stop;
   logic Clear;

   logic       sd_a, cp_a, run_a, done_a, exp_a, warn_a;
   logic       sd_b, cp_b, run_b, done_b, exp_b, warn_b;
   logic       sd_c, cp_c, run_c, done_c, exp_c, warn_c;
   logic [3:0] st_a, so_a, st_b, so_b, st_c, so_c;

   logic [7:0] model_a = 8'h00;
   logic [7:0] model_b = 8'h00;
   logic [7:0] model_c = 8'h00;

   int checks = 0;
   int errors = 0;

   game_timer_ctrl #(.TICK_DIV(4), .START_TENS(4'd0), .START_ONES(4'd3)) dut_a (
      .CLK(CLK), .RST(RST), .Start(Start), .Stop(Stop), .Clear(Clear),
      .TensIn(model_a[7:4]), .OnesIn(model_a[3:0]),
      .SetDigits(sd_a), .SetTens(st_a), .SetOnes(so_a), .CountPulse(cp_a),
      .Running(run_a), .Done(done_a), .Expired(exp_a), .Warn(warn_a)
   );

   game_timer_ctrl #(.TICK_DIV(4), .START_TENS(4'd1), .START_ONES(4'd0)) dut_b (
      .CLK(CLK), .RST(RST), .Start(Start), .Stop(Stop), .Clear(Clear),
      .TensIn(model_b[7:4]), .OnesIn(model_b[3:0]),
      .SetDigits(sd_b), .SetTens(st_b), .SetOnes(so_b), .CountPulse(cp_b),
      .Running(run_b), .Done(done_b), .Expired(exp_b), .Warn(warn_b)
   );

   game_timer_ctrl #(.TICK_DIV(4), .START_TENS(4'd0), .START_ONES(4'd0)) dut_c (
      .CLK(CLK), .RST(RST), .Start(Start), .Stop(Stop), .Clear(Clear),
      .TensIn(model_c[7:4]), .OnesIn(model_c[3:0]),
      .SetDigits(sd_c), .SetTens(st_c), .SetOnes(so_c), .CountPulse(cp_c),
      .Running(run_c), .Done(done_c), .Expired(exp_c), .Warn(warn_c)
   );

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      logic [3:0] t;
      logic [3:0] o;
      t = v[7:4];
      o = v[3:0];
      if (o == 4'd0) begin
         o = 4'd9;
         t = (t == 4'd0) ? 4'd9 : t - 4'd1;
      end else begin
         o = o - 4'd1;
      end
      return {t, o};
   endfunction

   always @(posedge CLK) begin
      if (sd_a) model_a <= {st_a, so_a};
      else if (cp_a) model_a <= bcd_dec(model_a);
      if (sd_b) model_b <= {st_b, so_b};
      else if (cp_b) model_b <= bcd_dec(model_b);
      if (sd_c) model_c <= {st_c, so_c};
      else if (cp_c) model_c <= bcd_dec(model_c);
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; Start = 1'b0; Stop = 1'b0; Clear = 1'b0;
      #1;
      step();
      RST = 1'b0;
      check("rst sd_a",   8'(sd_a),   8'd1);
      check("rst cp_a",   8'(cp_a),   8'd0);
      check("rst run_a",  8'(run_a),  8'd0);
      check("rst done_a", 8'(done_a), 8'd0);
      check("rst exp_a",  8'(exp_a),  8'd0);
      check("rst warn_a", 8'(warn_a), 8'd0);
      step();
      check("rst model_a", model_a, 8'h03);
      check("rst model_b", model_b, 8'h10);
      check("rst model_c", model_c, 8'h00);

      // Run to expiry: a counts 03->00, b counts 10->09->..., c starts at 00.
      for (int c = 0; c <= 14; c++) begin
         Start = (c == 0);
         check($sformatf("A cp_a c%0d", c),   8'(cp_a),   8'(c == 4 || c == 8 || c == 12));
         check($sformatf("A run_a c%0d", c),  8'(run_a),  8'(c >= 1 && c <= 12));
         check($sformatf("A done_a c%0d", c), 8'(done_a), 8'(c >= 13));
         check($sformatf("A exp_a c%0d", c),  8'(exp_a),  8'(c == 13));
         check($sformatf("A warn_a c%0d", c), 8'(warn_a), 8'(WARN_EN && c >= 1 && c <= 12));
         check($sformatf("A cp_b c%0d", c),   8'(cp_b),   8'(c == 4 || c == 8 || c == 12));
         check($sformatf("A warn_b c%0d", c), 8'(warn_b), 8'(WARN_EN && c >= 6));
         check($sformatf("A cp_c c%0d", c),   8'(cp_c),   8'd0);
         check($sformatf("A done_c c%0d", c), 8'(done_c), 8'(c >= 1));
         check($sformatf("A exp_c c%0d", c),  8'(exp_c),  8'(c == 1));
         if (c == 5)  check("A model_b c5", model_b, 8'h09);
         if (c == 13) check("A model_a c13", model_a, 8'h00);
         step();
      end

      // DONE ignores Start and Stop.
      Start = 1'b1; Stop = 1'b1;
      step();
      Start = 1'b0; Stop = 1'b0;
      check("done hold done_a", 8'(done_a), 8'd1);
      check("done hold exp_a",  8'(exp_a),  8'd0);
      check("done hold run_a",  8'(run_a),  8'd0);

      Clear = 1'b1;
      step();
      Clear = 1'b0;
      check("clr sd_a",   8'(sd_a),   8'd1);
      check("clr done_a", 8'(done_a), 8'd0);
      check("clr done_c", 8'(done_c), 8'd0);
      check("clr run_b",  8'(run_b),  8'd0);
      step();
      check("clr model_a", model_a, 8'h03);
      check("clr model_b", model_b, 8'h10);

      // Pause: Stop at 6, resume at 10; prescaler value is held across the pause.
      for (int c = 0; c <= 13; c++) begin
         Start = (c == 0 || c == 10);
         Stop  = (c == 6);
         check($sformatf("B cp_a c%0d", c),   8'(cp_a),   8'(c == 4 || c == 12));
         check($sformatf("B run_a c%0d", c),  8'(run_a),  8'((c >= 1 && c <= 6) || (c >= 11)));
         check($sformatf("B done_a c%0d", c), 8'(done_a), 8'd0);
         if (c == 13) check("B model_a c13", model_a, 8'h01);
         step();
      end
      Start = 1'b0; Stop = 1'b0;
      Clear = 1'b1;
      step();
      Clear = 1'b0;
      step();

      // Clear together with Start in RUN returns to IDLE and reloads the preset.
      for (int c = 0; c <= 8; c++) begin
         Start = (c == 0 || c == 6);
         Clear = (c == 6);
         check($sformatf("C cp_a c%0d", c),  8'(cp_a),  8'(c == 4));
         check($sformatf("C run_a c%0d", c), 8'(run_a), 8'(c >= 1 && c <= 6));
         check($sformatf("C sd_a c%0d", c),  8'(sd_a),  8'(c == 0 || c >= 7));
         if (c == 6) check("C model_a c6", model_a, 8'h02);
         if (c == 8) check("C model_a c8", model_a, 8'h03);
         step();
      end
      Start = 1'b0; Clear = 1'b0;

      // Restart gets a full period; RST lands in the tick cycle.
      for (int c = 0; c <= 4; c++) begin
         Start = (c == 0);
         if (c == 4) begin
            RST = 1'b1;
            Start = 1'b1;
         end
         check($sformatf("D cp_a c%0d", c),  8'(cp_a),  8'(c == 4));
         check($sformatf("D run_a c%0d", c), 8'(run_a), 8'(c >= 1 && c <= 4));
         step();
      end
      RST = 1'b0; Start = 1'b0;
      check("D rst sd_a",   8'(sd_a),   8'd1);
      check("D rst run_a",  8'(run_a),  8'd0);
      check("D rst cp_a",   8'(cp_a),   8'd0);
      check("D rst exp_a",  8'(exp_a),  8'd0);
      check("D rst warn_a", 8'(warn_a), 8'd0);
      check("D rst done_c", 8'(done_c), 8'd0);
      step();
      check("D model_a", model_a, 8'h03);

      // Stop in the tick cycle still issues that CountPulse.
      for (int c = 0; c <= 5; c++) begin
         Start = (c == 0);
         Stop  = (c == 4);
         check($sformatf("E cp_a c%0d", c),  8'(cp_a),  8'(c == 4));
         check($sformatf("E run_a c%0d", c), 8'(run_a), 8'(c >= 1 && c <= 4));
         step();
      end
      Stop = 1'b0;
      check("E model_a", model_a, 8'h02);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_timer_ctrl.md
GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100, clock cycles per count tick; legal values are 2 or more.
REQ-002 Parameter START_TENS, default 4'd6, tens digit of the preset; legal range 0..9.
REQ-003 Parameter START_ONES, default 4'd0, ones digit of the preset; legal range 0..9.
REQ-004 Port CLK, input, 1 bit: the only clock; all logic SHALL be on its posedge.
REQ-005 Port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port Start, input, 1 bit: start or resume request, sampled each cycle.
REQ-007 Port Stop, input, 1 bit: pause request, sampled each cycle.
REQ-008 Port Clear, input, 1 bit: abort and return to preset.
REQ-009 Port TensIn, input, 4 bits: current tens digit read back from the down-counter chain.
REQ-010 Port OnesIn, input, 4 bits: current ones digit read back from the down-counter chain.
REQ-011 Port SetDigits, output, 1 bit: load strobe to both counter digits.
REQ-012 Port SetTens, output, 4 bits: load value for the tens digit (constant START_TENS).
REQ-013 Port SetOnes, output, 4 bits: load value for the ones digit (constant START_ONES).
REQ-014 Port CountPulse, output, 1 bit: decrement strobe to the ones digit.
REQ-015 Port Running, output, 1 bit: high while in RUN.
REQ-016 Port Done, output, 1 bit: high while in DONE.
REQ-017 Port Expired, output, 1 bit: one-cycle pulse on entry to DONE.
REQ-018 Port Warn, output, 1 bit: low-time warning (see Configuration).

Function
REQ-019 The FSM SHALL have four states: IDLE, RUN, PAUSE and DONE.
REQ-020 Input priority SHALL be Clear > Start > Stop.
REQ-021 Clear SHALL move any state to IDLE on the next cycle.
REQ-022 IDLE: SetDigits = 1 continuously, so the counters hold the preset.
REQ-023 IDLE plus Start: go to RUN if the digits read back nonzero; go to DONE if they read 00.
REQ-024 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-025 A tick occurs when the prescaler equals TICK_DIV-1 in RUN.
REQ-026 CountPulse SHALL be combinational, high only in the tick cycle, exactly one cycle wide.
REQ-027 A tick with TensIn:OnesIn == 0:1 SHALL assert CountPulse and move to DONE the next cycle.
REQ-028 A tick with any other nonzero value SHALL assert CountPulse and stay in RUN; the digit chain handles the ones-to-tens borrow.
REQ-029 RUN plus Stop goes to PAUSE; Start in RUN is ignored; a Stop in the tick cycle still issues that CountPulse.
REQ-030 PAUSE holds the prescaler value and issues no CountPulse; Start returns to RUN and the prescaler resumes from the held value.
REQ-031 Entry from IDLE to RUN SHALL clear the prescaler to 0; the first tick comes TICK_DIV cycles after the Start cycle.
REQ-032 DONE ignores Start and Stop; only Clear or RST leaves DONE.
REQ-033 Expired SHALL be registered and high exactly in the first DONE cycle.
REQ-034 Running and Done SHALL be registered state decodes; SetDigits SHALL be 1 only in IDLE.
REQ-035 The prescaler width SHALL be $clog2(TICK_DIV) bits, and the prescaler SHALL never exceed TICK_DIV-1.

Reset
REQ-036 RST high at a posedge SHALL force IDLE, prescaler 0 and Expired 0 on the next cycle.
REQ-037 After reset the outputs SHALL be: SetDigits 1, CountPulse 0, Running 0, Done 0, Expired 0, Warn 0.
REQ-038 RST SHALL override every input, including in mid-RUN or in a tick cycle.

Configuration
REQ-039 The macro GAME_TIMER_WARN_EN SHALL control the warning feature.
REQ-040 With GAME_TIMER_WARN_EN defined, Warn SHALL be registered and high in RUN or PAUSE while TensIn == 0.
REQ-041 Without GAME_TIMER_WARN_EN, Warn SHALL be tied to 0 and no warning logic SHALL be synthesized.

Structure
REQ-042 Package timer_pkg SHALL hold the state enum timer_state_t and the default constants for TICK_DIV, START_TENS and START_ONES.
REQ-043 Sub-module tick_prescaler SHALL hold the counter, with enable, clear and tick outputs.
REQ-044 The BCD digit counters SHALL stay external to this block.

Verification (TICK_DIV=4, preset 0:3, with a two-digit down-counter model attached)
REQ-045 RST for 1 cycle -> SetDigits=1 and all other outputs 0; the model shows 0:3.
REQ-046 Start pulse at cycle 0 -> CountPulse at cycles 4, 8 and 12; Expired at cycle 13; Done stays 1.
REQ-047 Stop at cycle 6, Start at cycle 10 -> no CountPulse during the pause; the next CountPulse comes at cycle 12.
REQ-048 Preset 1:0, one tick -> the model shows 0:9; with GAME_TIMER_WARN_EN, Warn rises the next cycle.
REQ-049 Clear and Start together in RUN -> IDLE with SetDigits=1; the model reloads 0:3.
REQ-050 Preset 0:0 plus Start -> DONE next cycle; Expired for 1 cycle; CountPulse never asserted.
